multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It holds the fetched instruction in an internal instruction register and drives register-file, memory and PC control strobes. It talks to the shared instruction/data memory through a req/ready handshake. It replaces the single-cycle decode path in the top-level CPU.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_op_decode.sv | 25 ++
 rtl/multicycle_sequencer.sv | 150 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// PC source selects and the opcode classes produced by the decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LL    = 6'h30;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_JR,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BR,
        CL_J,
        CL_JAL,
        CL_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode classifier: maps opcode/funct of the held instruction
// onto the coarse class the sequencer steps on.
module mips_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class
);

    always_comb begin
        case (opcode)
            OP_RTYPE:                       op_class = (funct == FN_JR) ? CL_JR : CL_RTYPE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: op_class = CL_IALU;
            OP_LW, OP_LBU, OP_LHU, OP_LL:   op_class = CL_LOAD;
            OP_SB, OP_SH, OP_SW:            op_class = CL_STORE;
            OP_BEQ, OP_BNE:                 op_class = CL_BR;
            OP_J:                           op_class = CL_J;
            OP_JAL:                         op_class = CL_JAL;
            default:                        op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a req/ready
// memory handshake. Strobes are decoded combinationally from state and IR.
module multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned RA_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        memRead,
    output logic        memWr,
    output logic        irWr,
    output logic        pcWr,
    output logic [1:0]  pcSrc,
    output logic        aluSrcImm,
    output logic        regWr,
    output logic [4:0]  rd,
    output logic [2:0]  state,
    output logic        illegal
);

    localparam logic [4:0] RA_ADDR = 5'(RA_REG);

    state_t      state_q;
    logic [31:0] ir_q;
    op_class_t   cls;

    logic unused_ir;
    assign unused_ir = ^{ir_q[25:21], ir_q[10:6]};

    mips_op_decode u_decode (
        .opcode   (ir_q[31:26]),
        .funct    (ir_q[5:0]),
        .op_class (cls)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= instruction;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= (cls == CL_ILLEGAL) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    case (cls)
                        CL_RTYPE, CL_IALU:  state_q <= S_WB;
                        CL_LOAD, CL_STORE:  state_q <= S_MEM;
                        default:            state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready)
                        state_q <= (cls == CL_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_req   = 1'b0;
        memRead   = 1'b0;
        memWr     = 1'b0;
        irWr      = 1'b0;
        pcWr      = 1'b0;
        pcSrc     = PC_PLUS4;
        aluSrcImm = 1'b0;
        regWr     = 1'b0;
        rd        = '0;
        illegal   = 1'b0;
        state     = state_q;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                memRead = 1'b1;
                if (mem_ready) begin
                    irWr = 1'b1;
                    pcWr = 1'b1;
                end
            end
            S_DECODE: illegal = (cls == CL_ILLEGAL);
            S_EXEC: begin
                case (cls)
                    CL_IALU, CL_LOAD, CL_STORE: aluSrcImm = 1'b1;
                    CL_BR: begin
                        pcSrc = PC_BRANCH;
                        pcWr  = (ir_q[31:26] == OP_BNE) ? !zero : zero;
                    end
                    CL_J: begin
                        pcWr  = 1'b1;
                        pcSrc = PC_JUMP;
                    end
                    CL_JAL: begin
                        pcWr  = 1'b1;
                        pcSrc = PC_JUMP;
                        regWr = 1'b1;
                        rd    = RA_ADDR;
                    end
                    CL_JR: begin
                        pcWr  = 1'b1;
                        pcSrc = PC_JR;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                memRead = (cls == CL_LOAD);
                memWr   = (cls == CL_STORE);
            end
            S_WB: begin
                regWr = 1'b1;
                rd    = (cls == CL_RTYPE) ? ir_q[15:11] : ir_q[20:16];
            end
            default: ;
        endcase

        // Reset wins over everything, including a request held mid-handshake.
        if (rst) begin
            mem_req   = 1'b0;
            memRead   = 1'b0;
            memWr     = 1'b0;
            irWr      = 1'b0;
            pcWr      = 1'b0;
            pcSrc     = PC_PLUS4;
            aluSrcImm = 1'b0;
            regWr     = 1'b0;
            rd        = '0;
            illegal   = 1'b0;
            state     = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: a per-instruction cycle-plan model built from the opcode rules,
// compared against the sequencer's outputs every cycle.
module tb_multicycle_sequencer;

    localparam int RA = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, memRead, memWr, irWr, pcWr, aluSrcImm, regWr, illegal;
    logic [1:0]  pcSrc;
    logic [4:0]  rd;
    logic [2:0]  state;

    multicycle_sequencer #(.RA_REG(RA)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
        .zero(zero), .mem_req(mem_req), .memRead(memRead), .memWr(memWr),
        .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc), .aluSrcImm(aluSrcImm),
        .regWr(regWr), .rd(rd), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          tag;
        logic        rst, mem_ready, zero;
        logic [31:0] instr;
        logic        mem_req, memRead, memWr, irWr, pcWr;
        logic [1:0]  pcSrc;
        logic        aluSrcImm, regWr;
        logic [4:0]  rd;
        logic [2:0]  state;
        logic        illegal;
    } cyc_t;

    typedef enum int {K_R, K_JR, K_I, K_LD, K_ST, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_t;

    cyc_t plan[$];
    cyc_t cur;
    bit   chk = 1'b0;
    int   cur_tag = 0;
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   obs_pcwr[0:31];
    int   obs_regwr[0:31];
    int   obs_memwr[0:31];
    int   obs_memrd_mem[0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cycle, act, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == 6'h00) return (instr[5:0] == 6'h08) ? K_JR : K_R;
        if (op >= 6'h08 && op <= 6'h0F) return K_I;
        if (op == 6'h23 || op == 6'h24 || op == 6'h25 || op == 6'h30) return K_LD;
        if (op == 6'h28 || op == 6'h29 || op == 6'h2B) return K_ST;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        return K_ILL;
    endfunction

    // Idle-looking cycle: memory claims ready and zero is high so any strobe
    // that wrongly listens to them outside its phase shows up.
    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.tag = cur_tag;
        c.mem_ready = 1'b1;
        c.zero = 1'b1;
        c.instr = 32'hDEAD_BEEF;
        c.state = st;
        return c;
    endfunction

    task automatic push_reset();
        cyc_t c;
        c = blank(3'd0);
        c.rst = 1'b1;
        plan.push_back(c);
    endtask

    task automatic build(input logic [31:0] instr, input int fwait, input int mwait,
                         input logic z, input bit abort_in_mem);
        kind_t k;
        cyc_t  c;
        k = kind_of(instr);
        for (int i = 0; i < fwait; i++) begin
            c = blank(3'd0);
            c.mem_ready = 1'b0; c.mem_req = 1'b1; c.memRead = 1'b1;
            c.instr = 32'hFFFF_FFFF;
            plan.push_back(c);
        end
        c = blank(3'd0);
        c.instr = instr; c.mem_req = 1'b1; c.memRead = 1'b1; c.irWr = 1'b1; c.pcWr = 1'b1;
        plan.push_back(c);

        c = blank(3'd1);
        c.illegal = (k == K_ILL);
        plan.push_back(c);
        if (k == K_ILL) return;

        c = blank(3'd2);
        c.zero = z;
        case (k)
            K_I, K_LD, K_ST: c.aluSrcImm = 1'b1;
            K_BEQ: begin c.pcSrc = 2'b01; c.pcWr = z; end
            K_BNE: begin c.pcSrc = 2'b01; c.pcWr = !z; end
            K_J:   begin c.pcSrc = 2'b10; c.pcWr = 1'b1; end
            K_JAL: begin c.pcSrc = 2'b10; c.pcWr = 1'b1; c.regWr = 1'b1; c.rd = 5'(RA); end
            K_JR:  begin c.pcSrc = 2'b11; c.pcWr = 1'b1; end
            default: ;
        endcase
        plan.push_back(c);
        if (k == K_BEQ || k == K_BNE || k == K_J || k == K_JAL || k == K_JR) return;

        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i <= mwait; i++) begin
                c = blank(3'd3);
                c.mem_req = 1'b1; c.memRead = (k == K_LD); c.memWr = (k == K_ST);
                c.mem_ready = (i == mwait) && !abort_in_mem;
                if (abort_in_mem && i == mwait) begin
                    push_reset();
                    return;
                end
                plan.push_back(c);
            end
            if (k == K_ST) return;
        end

        c = blank(3'd4);
        c.regWr = 1'b1;
        c.rd = (k == K_R) ? instr[15:11] : instr[20:16];
        plan.push_back(c);
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("mem_req",   32'(mem_req),   32'(cur.mem_req));
            check("memRead",   32'(memRead),   32'(cur.memRead));
            check("memWr",     32'(memWr),     32'(cur.memWr));
            check("irWr",      32'(irWr),      32'(cur.irWr));
            check("pcWr",      32'(pcWr),      32'(cur.pcWr));
            check("pcSrc",     32'(pcSrc),     32'(cur.pcSrc));
            check("aluSrcImm", 32'(aluSrcImm), 32'(cur.aluSrcImm));
            check("regWr",     32'(regWr),     32'(cur.regWr));
            check("rd",        32'(rd),        32'(cur.rd));
            check("state",     32'(state),     32'(cur.state));
            check("illegal",   32'(illegal),   32'(cur.illegal));
            check("rd_wr_excl", 32'(memRead & memWr), 32'd0);
            if (pcWr === 1'b1)  obs_pcwr[cur.tag]++;
            if (regWr === 1'b1) obs_regwr[cur.tag]++;
            if (memWr === 1'b1) obs_memwr[cur.tag]++;
            if (memRead === 1'b1 && state == 3'd3) obs_memrd_mem[cur.tag]++;
        end
    end

    initial begin
        int s0;
        cyc_t last;
        for (int i = 0; i < 32; i++) begin
            obs_pcwr[i] = 0; obs_regwr[i] = 0; obs_memwr[i] = 0; obs_memrd_mem[i] = 0;
        end

        cur_tag = 0; push_reset(); push_reset();

        cur_tag = 1; s0 = plan.size();
        build(32'h012A_4020, 0, 0, 1'b0, 1'b0);                 // add $t0
        last = plan[$];
        check("pin_add_len", 32'(plan.size() - s0), 32'd4);
        check("pin_add_rd", 32'(last.rd), 32'd8);

        cur_tag = 2; s0 = plan.size();
        build(32'h8C09_0004, 0, 2, 1'b0, 1'b0);                 // lw $t1 with stall
        last = plan[$];
        check("pin_lw_len", 32'(plan.size() - s0), 32'd7);
        check("pin_lw_rd", 32'(last.rd), 32'd9);

        cur_tag = 3; s0 = plan.size();
        build(32'hAC09_0004, 0, 0, 1'b0, 1'b0);                 // sw
        check("pin_sw_len", 32'(plan.size() - s0), 32'd4);

        cur_tag = 4; build(32'h1109_0003, 0, 0, 1'b1, 1'b0);    // beq, zero=1
        last = plan[$];
        check("pin_beq_pcwr", 32'(last.pcWr), 32'd1);
        cur_tag = 5; build(32'h1509_0003, 0, 0, 1'b1, 1'b0);    // bne, zero=1
        last = plan[$];
        check("pin_bne_pcwr", 32'(last.pcWr), 32'd0);
        cur_tag = 6; build(32'h1509_0003, 0, 0, 1'b0, 1'b0);    // bne, zero=0
        cur_tag = 7; s0 = plan.size();
        build(32'h0C00_0010, 0, 0, 1'b0, 1'b0);                 // jal
        last = plan[$];
        check("pin_jal_len", 32'(plan.size() - s0), 32'd3);
        check("pin_jal_rd", 32'(last.rd), 32'd31);
        cur_tag = 8;  build(32'h03E0_0008, 0, 0, 1'b0, 1'b0);   // jr $ra
        cur_tag = 9;  build(32'h0800_0010, 0, 0, 1'b0, 1'b0);   // j
        cur_tag = 10; build(32'h2128_0005, 1, 0, 1'b0, 1'b0);   // addi, fetch wait
        cur_tag = 11; build(32'h35AA_0001, 0, 0, 1'b0, 1'b0);   // ori
        cur_tag = 12; build(32'h3C0B_1234, 0, 0, 1'b0, 1'b0);   // lui
        cur_tag = 13; build(32'h912C_0000, 0, 1, 1'b0, 1'b0);   // lbu
        cur_tag = 14; build(32'hA12C_0000, 2, 0, 1'b0, 1'b0);   // sb, fetch wait 2
        cur_tag = 15; s0 = plan.size();
        build(32'hFC00_0000, 0, 0, 1'b0, 1'b0);                 // opcode 0x3F
        last = plan[$];
        check("pin_ill_len", 32'(plan.size() - s0), 32'd2);
        check("pin_ill_pulse", 32'(last.illegal), 32'd1);
        cur_tag = 16; build(32'h8C09_0004, 0, 1, 1'b0, 1'b1);   // lw, reset in MEM stall
        cur_tag = 17; build(32'h012A_4020, 0, 0, 1'b0, 1'b0);   // add after reset
        cur_tag = 18; build(32'h0109_5022, 0, 0, 1'b0, 1'b0);   // sub $t2

        while (plan.size() > 0) begin
            @(posedge clk);
            #1;
            cur         = plan.pop_front();
            rst         = cur.rst;
            mem_ready   = cur.mem_ready;
            zero        = cur.zero;
            instruction = cur.instr;
            chk         = 1'b1;
            cycle++;
        end
        @(negedge clk);
        #1 chk = 1'b0;

        check("add_pcwr_once",  32'(obs_pcwr[1]), 32'd1);
        check("add_regwr_once", 32'(obs_regwr[1]), 32'd1);
        check("lw_memrd_mem",   32'(obs_memrd_mem[2]), 32'd3);
        check("sw_memwr_once",  32'(obs_memwr[3]), 32'd1);
        check("sw_no_regwr",    32'(obs_regwr[3]), 32'd0);
        check("jr_no_regwr",    32'(obs_regwr[8]), 32'd0);
        check("abort_no_regwr", 32'(obs_regwr[16]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
